wb_commit_ctrl: RTL and testbench

- Writeback-stage commit controller for the 5-stage LoongArch CPU; it is the requester side of the CSR file interface.
- Accepts retiring instructions from MEM over a valid/allowin handshake. Resolves exception priority, including the pending interrupt.
- Drives CSR read/write, wb_ex and ertn_flush pulses, and the register-file write.
- Holds a pipeline flush/redirect until fetch accepts it.

---
 rtl/wb_commit_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_wb_commit_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_ctrl.sv
// Writeback-stage commit controller: retires MEM instructions, resolves
// exceptions, drives CSR/regfile writes and holds flush redirects for fetch.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   ms_to_ws_valid/ms_*  instruction bundle from MEM; ws_allowin back
//   csr_re/num/we/wmask/wvalue, csr_rvalue, has_int, ex_entry, ertn_entry
//                        CSR file requester side
//   wb_ex/ecode/esubcode/pc/vaddr, ertn_flush, ws_flush
//                        commit pulses and pipeline squash
//   rf_we/waddr/wdata    register-file write
//   redir_valid/pc/ready redirect handshake to fetch
module wb_commit_ctrl #(
    parameter int PC_W    = 32,
    parameter int CSR_N_W = 14
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ms_to_ws_valid,
    output logic               ws_allowin,
    input  logic [PC_W-1:0]    ms_pc,
    input  logic [2:0]         ms_op,
    input  logic [2:0]         ms_exc,
    input  logic [PC_W-1:0]    ms_vaddr,
    input  logic [CSR_N_W-1:0] ms_csr_num,
    input  logic [31:0]        ms_rj_val,
    input  logic [31:0]        ms_rd_val,
    input  logic               ms_rf_we,
    input  logic [4:0]         ms_rf_waddr,
    output logic               csr_re,
    output logic [CSR_N_W-1:0] csr_num,
    input  logic [31:0]        csr_rvalue,
    output logic               csr_we,
    output logic [31:0]        csr_wmask,
    output logic [31:0]        csr_wvalue,
    input  logic               has_int,
    input  logic [PC_W-1:0]    ex_entry,
    input  logic [PC_W-1:0]    ertn_entry,
    output logic               wb_ex,
    output logic [5:0]         wb_ecode,
    output logic [8:0]         wb_esubcode,
    output logic [PC_W-1:0]    wb_pc,
    output logic [PC_W-1:0]    wb_vaddr,
    output logic               ertn_flush,
    output logic               ws_flush,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic               redir_valid,
    output logic [PC_W-1:0]    redir_pc,
    input  logic               redir_ready
);

    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;
    localparam logic [2:0] OP_SYSCALL = 3'd5;
    localparam logic [2:0] OP_BREAK   = 3'd6;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic               ws_valid;
    logic [PC_W-1:0]    ws_pc;
    logic [2:0]         ws_op;
    logic [2:0]         ws_exc;
    logic [PC_W-1:0]    ws_vaddr;
    logic [CSR_N_W-1:0] ws_csr_num;
    logic [31:0]        ws_rj_val;
    logic [31:0]        ws_rd_val;
    logic               ws_rf_we;
    logic [4:0]         ws_rf_waddr;

    logic commit;
    logic is_sys;
    logic is_brk;
    logic ex_hit;
    logic ws_cap;

    // Held low during reset so every output reads 0 while resetn=0.
    assign ws_allowin = resetn;

    assign commit = ws_valid && (state == RUN);
    assign is_sys = (ws_op == OP_SYSCALL);
    assign is_brk = (ws_op == OP_BREAK);
    assign ex_hit = has_int | (|ws_exc) | is_sys | is_brk;
    assign ws_flush = wb_ex | ertn_flush;
    assign ws_cap = (state == RUN) && !ws_flush && ms_to_ws_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wb_ex       = 1'b0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_pc       = '0;
        wb_vaddr    = '0;
        ertn_flush  = 1'b0;
        csr_re      = 1'b0;
        csr_num     = '0;
        csr_we      = 1'b0;
        csr_wmask   = '0;
        csr_wvalue  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        if (commit) begin
            if (ex_hit) begin
                wb_ex = 1'b1;
                wb_pc = ws_pc;
                priority case (1'b1)
                    has_int: wb_ecode = ECODE_INT;
                    ws_exc[0]: begin
                        wb_ecode = ECODE_ADEF;
                        wb_vaddr = ws_pc;
                    end
                    ws_exc[1]: wb_ecode = ECODE_INE;
                    is_sys:    wb_ecode = ECODE_SYS;
                    is_brk:    wb_ecode = ECODE_BRK;
                    default: begin
                        wb_ecode = ECODE_ALE;
                        wb_vaddr = ws_vaddr;
                    end
                endcase
            end else begin
                case (ws_op)
                    OP_ERTN: ertn_flush = 1'b1;
                    OP_CSRRD, OP_CSRWR, OP_CSRXCHG: begin
                        csr_re   = 1'b1;
                        csr_num  = ws_csr_num;
                        rf_we    = ws_rf_we;
                        rf_waddr = ws_rf_waddr;
                        // Old CSR value goes to rd in the same cycle as the write.
                        rf_wdata = csr_rvalue;
                        if (ws_op != OP_CSRRD) begin
                            csr_we     = 1'b1;
                            csr_wvalue = ws_rd_val;
                            csr_wmask  = (ws_op == OP_CSRWR) ? '1 : ws_rj_val;
                        end
                    end
                    default: begin
                        rf_we    = ws_rf_we;
                        rf_waddr = ws_rf_waddr;
                        rf_wdata = ws_rd_val;
                    end
                endcase
            end
        end
        if (state == RUN) begin
            if (wb_ex || ertn_flush) begin
                state_nxt = FLUSH;
            end
        end else if (redir_ready) begin
            state_nxt = RUN;
        end
    end

    // Entry is sampled on the commit cycle, before the CSR update lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else if (state == RUN && ws_flush) begin
            redir_valid <= 1'b1;
            redir_pc    <= wb_ex ? ex_entry : ertn_entry;
        end else if (state == FLUSH && redir_ready) begin
            redir_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid    <= 1'b0;
            ws_pc       <= '0;
            ws_op       <= '0;
            ws_exc      <= '0;
            ws_vaddr    <= '0;
            ws_csr_num  <= '0;
            ws_rj_val   <= '0;
            ws_rd_val   <= '0;
            ws_rf_we    <= 1'b0;
            ws_rf_waddr <= '0;
        end else begin
            ws_valid <= ws_cap;
            if (ws_cap) begin
                ws_pc       <= ms_pc;
                ws_op       <= ms_op;
                ws_exc      <= ms_exc;
                ws_vaddr    <= ms_vaddr;
                ws_csr_num  <= ms_csr_num;
                ws_rj_val   <= ms_rj_val;
                ws_rd_val   <= ms_rd_val;
                ws_rf_we    <= ms_rf_we;
                ws_rf_waddr <= ms_rf_waddr;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Randomized and directed bench for wb_commit_ctrl against a
// cycle-level reference model of the commit rules.
module tb_wb_commit_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  op;
        logic [2:0]  exc;
        logic [31:0] vaddr;
        logic [13:0] num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic        we;
        logic [4:0]  wa;
    } instr_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [2:0]  ms_op;
    logic [2:0]  ms_exc;
    logic [31:0] ms_vaddr;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_rj_val;
    logic [31:0] ms_rd_val;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        ws_flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    always #5 clk = ~clk;

    wb_commit_ctrl dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_op(ms_op), .ms_exc(ms_exc),
        .ms_vaddr(ms_vaddr), .ms_csr_num(ms_csr_num),
        .ms_rj_val(ms_rj_val), .ms_rd_val(ms_rd_val),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_ready(redir_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: what sits in WB, whether a redirect is pending.
    instr_t      cur;
    instr_t      m_ins, n_ins;
    bit          m_have, n_have;
    bit          m_flush, n_flush;
    logic [31:0] m_rpc, n_rpc;

    function automatic instr_t mk(input logic [2:0] op, input logic [2:0] exc,
                                  input logic [31:0] pc, input logic [13:0] num,
                                  input logic [31:0] rj, input logic [31:0] rd,
                                  input logic [31:0] va, input logic we,
                                  input logic [4:0] wa);
        instr_t i;
        i.pc = pc; i.op = op; i.exc = exc; i.vaddr = va; i.num = num;
        i.rj = rj; i.rd = rd; i.we = we; i.wa = wa;
        return i;
    endfunction

    task automatic set_ins(input bit v, input instr_t i);
        cur = i;
        ms_to_ws_valid = v;
        ms_pc = i.pc; ms_op = i.op; ms_exc = i.exc; ms_vaddr = i.vaddr;
        ms_csr_num = i.num; ms_rj_val = i.rj; ms_rd_val = i.rd;
        ms_rf_we = i.we; ms_rf_waddr = i.wa;
    endtask

    task automatic model_reset();
        m_have = 0; m_flush = 0; m_rpc = '0; m_ins = '0;
    endtask

    task automatic settle_check();
        bit          hit[6];
        logic [5:0]  code[6];
        int          k;
        bit          e_ex, e_ertn, e_re, e_we, e_rfwe;
        logic [5:0]  e_ecode;
        logic [31:0] e_pc, e_va, e_wmask, e_wval, e_wdata;
        logic [13:0] e_num;
        logic [4:0]  e_wa;
        #1;
        e_ex = 0; e_ertn = 0; e_re = 0; e_we = 0; e_rfwe = 0;
        e_ecode = 0; e_pc = 0; e_va = 0; e_wmask = 0; e_wval = 0;
        e_wdata = 0; e_num = 0; e_wa = 0;
        if (m_have && !m_flush) begin
            hit = '{has_int, m_ins.exc[0], m_ins.exc[1],
                    m_ins.op == 3'd5, m_ins.op == 3'd6, m_ins.exc[2]};
            code = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
            k = -1;
            for (int i = 0; i < 6; i++)
                if (hit[i] && k < 0) k = i;
            if (k >= 0) begin
                e_ex = 1;
                e_ecode = code[k];
                e_pc = m_ins.pc;
                if (e_ecode == 6'h08) e_va = m_ins.pc;
                if (e_ecode == 6'h09) e_va = m_ins.vaddr;
            end else if (m_ins.op == 3'd4) begin
                e_ertn = 1;
            end else if (m_ins.op >= 3'd1 && m_ins.op <= 3'd3) begin
                e_re = 1;
                e_num = m_ins.num;
                e_we = (m_ins.op != 3'd1);
                if (m_ins.op == 3'd2) e_wmask = 32'hFFFF_FFFF;
                if (m_ins.op == 3'd3) e_wmask = m_ins.rj;
                if (e_we) e_wval = m_ins.rd;
                e_rfwe = m_ins.we;
                e_wa = m_ins.wa;
                e_wdata = csr_rvalue;
            end else begin
                e_rfwe = m_ins.we;
                e_wa = m_ins.wa;
                e_wdata = m_ins.rd;
            end
        end
        chk("allowin", ws_allowin, 1);
        chk("wb_ex", wb_ex, e_ex);
        chk("ecode", wb_ecode, e_ecode);
        chk("esubcode", wb_esubcode, 0);
        chk("wb_pc", wb_pc, e_pc);
        chk("wb_vaddr", wb_vaddr, e_va);
        chk("ertn_flush", ertn_flush, e_ertn);
        chk("ws_flush", ws_flush, e_ex | e_ertn);
        chk("csr_re", csr_re, e_re);
        chk("csr_num", csr_num, e_num);
        chk("csr_we", csr_we, e_we);
        chk("csr_wmask", csr_wmask, e_wmask);
        chk("csr_wvalue", csr_wvalue, e_wval);
        chk("rf_we", rf_we, e_rfwe);
        chk("rf_waddr", rf_waddr, e_wa);
        chk("rf_wdata", rf_wdata, e_wdata);
        chk("redir_valid", redir_valid, m_flush);
        if (m_flush) chk("redir_pc", redir_pc, m_rpc);
        n_flush = m_flush;
        n_rpc = m_rpc;
        if (m_flush && redir_ready) n_flush = 0;
        if (e_ex || e_ertn) begin
            n_flush = 1;
            n_rpc = e_ex ? ex_entry : ertn_entry;
        end
        n_have = !m_flush && !(e_ex || e_ertn) && ms_to_ws_valid;
        n_ins = n_have ? cur : m_ins;
    endtask

    task automatic adv();
        @(posedge clk);
        m_have = n_have; m_ins = n_ins; m_flush = n_flush; m_rpc = n_rpc;
        #1;
    endtask

    task automatic cycle();
        settle_check();
        adv();
    endtask

    task automatic idle();
        set_ins(0, '0);
    endtask

    task automatic drain();
        idle();
        redir_ready = 1;
        cycle();
        redir_ready = 0;
    endtask

    instr_t ri;

    initial begin
        resetn = 0;
        idle();
        csr_rvalue = 0; has_int = 0; ex_entry = 0; ertn_entry = 0;
        redir_ready = 0;
        model_reset();
        #12;
        chk("rst_allowin", ws_allowin, 0);
        chk("rst_redir", redir_valid, 0);
        chk("rst_wb_ex", wb_ex, 0);
        chk("rst_rf_we", rf_we, 0);
        @(posedge clk); #1;
        resetn = 1;

        // csrxchg
        csr_rvalue = 32'hAAAA5555;
        set_ins(1, mk(3'd3, 0, 32'h1c000000, 14'h30, 32'h0000FFFF,
                      32'h12345678, 0, 1, 5'd4));
        cycle();
        idle();
        settle_check();
        chk("xchg_we", csr_we, 1);
        chk("xchg_mask", csr_wmask, 32'h0000FFFF);
        chk("xchg_val", csr_wvalue, 32'h12345678);
        chk("xchg_rfwe", rf_we, 1);
        chk("xchg_wdata", rf_wdata, 32'hAAAA5555);
        adv();
        cycle();

        // syscall, redirect held through 3 not-ready cycles
        ex_entry = 32'h1c008000;
        set_ins(1, mk(3'd5, 0, 32'h1c000100, 0, 0, 0, 0, 1, 5'd1));
        cycle();
        idle();
        settle_check();
        chk("sys_ex", wb_ex, 1);
        chk("sys_ecode", wb_ecode, 6'h0B);
        chk("sys_pc", wb_pc, 32'h1c000100);
        adv();
        ex_entry = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("sys_hold_v", redir_valid, 1);
            chk("sys_hold_pc", redir_pc, 32'h1c008000);
            adv();
        end
        redir_ready = 1;
        cycle();
        redir_ready = 0;
        settle_check();
        chk("sys_drop", redir_valid, 0);
        adv();

        // priority: interrupt over ADEF+INE, then ADEF over INE
        has_int = 1;
        set_ins(1, mk(3'd0, 3'b011, 32'h1c000444, 0, 0, 0, 0, 1, 5'd2));
        cycle();
        idle();
        settle_check();
        chk("pri_int", wb_ecode, 6'h00);
        chk("pri_int_ex", wb_ex, 1);
        adv();
        has_int = 0;
        drain();
        set_ins(1, mk(3'd0, 3'b011, 32'h1c000444, 0, 0, 0, 0, 1, 5'd2));
        cycle();
        idle();
        settle_check();
        chk("pri_adef", wb_ecode, 6'h08);
        chk("pri_sub", wb_esubcode, 0);
        chk("pri_va", wb_vaddr, 32'h1c000444);
        adv();
        drain();

        // ALE on csrwr
        set_ins(1, mk(3'd2, 3'b100, 32'h1c000500, 14'h5, 0, 32'h77, 32'h3,
                      1, 5'd6));
        cycle();
        idle();
        settle_check();
        chk("ale_ecode", wb_ecode, 6'h09);
        chk("ale_va", wb_vaddr, 32'h3);
        chk("ale_csrwe", csr_we, 0);
        chk("ale_rfwe", rf_we, 0);
        adv();
        drain();

        // ertn followed by two back-to-back instructions
        ertn_entry = 32'h1c000200;
        set_ins(1, mk(3'd4, 0, 32'h1c000600, 0, 0, 0, 0, 0, 0));
        cycle();
        set_ins(1, mk(3'd2, 0, 32'h1c000604, 14'h6, 0, 32'h99, 0, 1, 5'd7));
        settle_check();
        chk("ertn_pulse", ertn_flush, 1);
        chk("ertn_wsfl", ws_flush, 1);
        adv();
        ertn_entry = 0;
        set_ins(1, mk(3'd0, 0, 32'h1c000608, 0, 0, 32'h55, 0, 1, 5'd8));
        settle_check();
        chk("ertn_once", ertn_flush, 0);
        chk("ertn_rpc", redir_pc, 32'h1c000200);
        chk("sq1_csrwe", csr_we, 0);
        adv();
        idle();
        redir_ready = 1;
        settle_check();
        chk("sq2_rfwe", rf_we, 0);
        chk("sq2_csrwe", csr_we, 0);
        adv();
        redir_ready = 0;
        settle_check();
        chk("sq3_rfwe", rf_we, 0);
        adv();

        // async reset in the middle of a FLUSH
        ex_entry = 32'h1c00abc0;
        set_ins(1, mk(3'd6, 0, 32'h1c000700, 0, 0, 0, 0, 0, 0));
        cycle();
        idle();
        cycle();
        settle_check();
        chk("pre_rst_v", redir_valid, 1);
        resetn = 0;
        #1;
        chk("arst_redir", redir_valid, 0);
        chk("arst_allow", ws_allowin, 0);
        chk("arst_wsfl", ws_flush, 0);
        chk("arst_csrwe", csr_we, 0);
        chk("arst_rfwe", rf_we, 0);
        @(posedge clk); #1;
        resetn = 1;
        model_reset();
        chk("arst_rpc", redir_pc, 0);
        set_ins(1, mk(3'd0, 0, 32'h1c000800, 0, 0, 32'hCAFE, 0, 1, 5'd9));
        cycle();
        idle();
        settle_check();
        chk("post_rst_rfwe", rf_we, 1);
        adv();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            ri.pc = $urandom;
            ri.op = 3'($urandom_range(0, 6));
            ri.exc = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            ri.vaddr = $urandom;
            ri.num = 14'($urandom);
            ri.rj = $urandom;
            ri.rd = $urandom;
            ri.we = 1'($urandom);
            ri.wa = 5'($urandom);
            set_ins($urandom_range(0, 9) < 7, ri);
            has_int = ($urandom_range(0, 7) == 0);
            csr_rvalue = $urandom;
            ex_entry = $urandom;
            ertn_entry = $urandom;
            redir_ready = 1'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
